// File: rtl/game_pkg.sv
// Game-wide types and constants shared by the level sequencer and movement controller.
package game_pkg;
  typedef logic [1:0] level_t;

  typedef enum logic [1:0] {PLAY, SWITCH, SETTLE, WON} lvl_state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  localparam logic [1:0] CHAR_IDLE = 2'b00;
  localparam logic [1:0] CHAR_MOVE = 2'b01;
  localparam logic [1:0] CHAR_FALL = 2'b10;

  localparam int SCREEN_H   = vga_pkg::VER_PIXELS;
  localparam int REC_HEIGHT = 63;
endpackage

// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 1024x768 display mode.
package vga_pkg;
  localparam int VER_PIXELS = 768;
  localparam int HOR_PIXELS = 1024;
endpackage

// File: rtl/frame_edge_det.sv
// One-cycle frame_start pulse on the rising edge of vertical blank.
module frame_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic vblnk,
  output logic frame_start
);
  logic vblnk_d;
  logic armed;

  // NOTE: async active-low reset; flops use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d <= 1'b0;
      armed   <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
      if (!vblnk) armed <= 1'b1;
    end
  end

  // A blank already in progress at reset release must not count as a new frame.
  assign frame_start = vblnk & ~vblnk_d & armed;
endmodule

// File: rtl/level_ctl.sv
// Frame-synchronous level sequencer: detects screen exits, swaps levels, freezes movement while settling.
module level_ctl
  import game_pkg::*;
#(
  parameter int NUM_LEVELS    = 4,
  parameter int TOP_MARGIN    = 2,
  parameter int BOT_MARGIN    = 2,
  parameter int ENTRY_MARGIN  = 8,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic [11:0] value_y,
  input  logic [1:0]  character_state,
  output logic [1:0]  level,
  output logic        level_changed,
  output logic        pos_load,
  output logic [11:0] pos_y,
  output logic        freeze,
  output logic        game_won
);
  localparam logic [11:0] TOP_LIMIT  = 12'(TOP_MARGIN);
  localparam logic [11:0] SCREEN_LIM = 12'(SCREEN_H);
  localparam logic [11:0] BOT_LIMIT  = 12'(SCREEN_H - REC_HEIGHT - BOT_MARGIN);
  localparam logic [11:0] UP_ENTRY   = 12'(SCREEN_H - REC_HEIGHT - 1 - ENTRY_MARGIN);
  localparam logic [11:0] DOWN_ENTRY = 12'(ENTRY_MARGIN);
  localparam level_t      LAST_LEVEL = level_t'(NUM_LEVELS - 1);
  localparam logic [3:0]  SETTLE_LD  = 4'(SETTLE_FRAMES);

  logic       frame_start;
  lvl_state_t state, state_nxt;
  dir_t       dir, dir_nxt;
  level_t     level_nxt;
  logic [3:0] settle_cnt, settle_nxt;
  logic       changed_nxt, load_nxt;
  logic [11:0] pos_y_nxt;
  logic       top_exit, bot_exit;

  frame_edge_det u_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .vblnk       (vblnk),
    .frame_start (frame_start)
  );

  // Values at or above the screen height are a jump that wrapped below zero.
  assign top_exit = (value_y < TOP_LIMIT) || (value_y >= SCREEN_LIM);
  assign bot_exit = (value_y > BOT_LIMIT);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    dir_nxt     = dir;
    level_nxt   = level;
    settle_nxt  = settle_cnt;
    changed_nxt = 1'b0;
    load_nxt    = 1'b0;
    pos_y_nxt   = '0;
    if (frame_start) begin
      case (state)
        PLAY: begin
          if (top_exit) begin
            if (level == LAST_LEVEL) begin
              state_nxt = WON;
            end else begin
              dir_nxt   = DIR_UP;
              state_nxt = SWITCH;
            end
          end else if (bot_exit && character_state == CHAR_FALL && level != '0) begin
            dir_nxt   = DIR_DOWN;
            state_nxt = SWITCH;
          end
        end
        SWITCH: begin
          level_nxt   = (dir == DIR_UP) ? level_t'(level + 2'd1) : level_t'(level - 2'd1);
          pos_y_nxt   = (dir == DIR_UP) ? UP_ENTRY : DOWN_ENTRY;
          changed_nxt = 1'b1;
          load_nxt    = 1'b1;
          settle_nxt  = SETTLE_LD;
          state_nxt   = SETTLE;
        end
        SETTLE: begin
          settle_nxt = settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) state_nxt = PLAY;
        end
        WON:     state_nxt = WON;
        default: state_nxt = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PLAY;
      dir           <= DIR_UP;
      level         <= '0;
      settle_cnt    <= '0;
      level_changed <= 1'b0;
      pos_load      <= 1'b0;
      pos_y         <= '0;
    end else begin
      state         <= state_nxt;
      dir           <= dir_nxt;
      level         <= level_nxt;
      settle_cnt    <= settle_nxt;
      level_changed <= changed_nxt;
      pos_load      <= load_nxt;
      pos_y         <= pos_y_nxt;
    end
  end

  assign freeze   = (state != PLAY);
  assign game_won = (state == WON);
endmodule

// File: tb/tb_level_ctl.sv
// Self-checking bench for level_ctl: directed scenarios plus randomized frames against a frame-level model.
module tb_level_ctl;
  localparam int NUM_LEVELS = 4;
  localparam int SETTLE     = 2;
  localparam int SCR_H      = 768;
  localparam int REC_H      = 63;
  localparam int UP_POS     = SCR_H - REC_H - 1 - 8;
  localparam int DOWN_POS   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblnk = 1'b0;
  logic [11:0] value_y = 12'd400;
  logic [1:0]  character_state = 2'b00;
  logic [1:0]  level;
  logic        level_changed, pos_load, freeze, game_won;
  logic [11:0] pos_y;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level reference model.
  int m_level, m_pending, m_settle;
  bit m_won;
  int exp_pulse, exp_pos, exp_freeze;

  level_ctl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .vblnk           (vblnk),
    .value_y         (value_y),
    .character_state (character_state),
    .level           (level),
    .level_changed   (level_changed),
    .pos_load        (pos_load),
    .pos_y           (pos_y),
    .freeze          (freeze),
    .game_won        (game_won)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_pending = 0; m_settle = 0; m_won = 0;
  endtask

  task automatic model_frame(input int y, input int cs);
    exp_pulse = 0;
    exp_pos   = 0;
    if (m_won) begin
    end else if (m_pending != 0) begin
      m_level  += m_pending;
      exp_pulse = 1;
      exp_pos   = (m_pending > 0) ? UP_POS : DOWN_POS;
      m_pending = 0;
      m_settle  = SETTLE;
    end else if (m_settle > 0) begin
      m_settle--;
    end else if (y < 2 || y >= SCR_H) begin
      if (m_level < NUM_LEVELS - 1) m_pending = 1;
      else m_won = 1;
    end else if (y > SCR_H - REC_H - 2 && cs == 2 && m_level > 0) begin
      m_pending = -1;
    end
    exp_freeze = (m_won || m_pending != 0 || m_settle > 0) ? 1 : 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, level, 0);
    check({tag, "_chg"}, level_changed, 0);
    check({tag, "_load"}, pos_load, 0);
    check({tag, "_pos_y"}, pos_y, 0);
    check({tag, "_freeze"}, freeze, 0);
    check({tag, "_won"}, game_won, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic frame(input logic [11:0] y, input logic [1:0] cs, input bit glitch);
    @(negedge clk);
    vblnk = 1'b0;
    character_state = cs;
    value_y = glitch ? 12'd0 : y;
    repeat (3) @(negedge clk);
    value_y = y;
    repeat (2) @(negedge clk);
    vblnk = 1'b1;
    model_frame(int'(y), int'(cs));
    @(negedge clk);
    check("level", level, m_level);
    check("level_changed", level_changed, exp_pulse);
    check("pos_load", pos_load, exp_pulse);
    check("pos_y", pos_y, exp_pos);
    check("freeze", freeze, exp_freeze);
    check("game_won", game_won, m_won);
    @(negedge clk);
    check("changed_end", level_changed, 0);
    check("pos_y_end", pos_y, 0);
    check("freeze_hold", freeze, exp_freeze);
  endtask

  initial begin
    int won_frames;
    logic [11:0] y;
    logic [1:0]  cs;

    // Blank already high through reset release must not start a frame.
    vblnk = 1'b1;
    value_y = 12'd0;
    do_reset();
    repeat (3) @(negedge clk);
    check("no_frame_after_reset", freeze, 0);

    // Top exit level 0 -> 1, then settle.
    frame(12'd1, 2'b01, 0);
    repeat (3) frame(12'd400, 2'b00, 0);
    // Underflow wrap on level 1 -> 2.
    frame(12'hFFA, 2'b01, 0);
    repeat (3) frame(12'd400, 2'b00, 0);
    // Bottom exit needs falling state.
    frame(12'd704, 2'b01, 0);
    frame(12'd704, 2'b10, 0);
    repeat (3) frame(12'd400, 2'b00, 0);
    frame(12'd704, 2'b10, 0);
    repeat (3) frame(12'd400, 2'b00, 0);
    // Level 0 floor ignored.
    frame(12'd704, 2'b10, 0);
    // Exit value between frames only.
    frame(12'd400, 2'b01, 1);
    frame(12'd400, 2'b01, 1);

    // Asynchronous reset in the middle of SETTLE.
    frame(12'd0, 2'b01, 0);
    frame(12'd400, 2'b00, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    frame(12'd400, 2'b00, 0);

    // Climb to the last level and win.
    repeat (3) begin
      frame(12'd0, 2'b01, 0);
      repeat (3) frame(12'd400, 2'b00, 0);
    end
    frame(12'd0, 2'b01, 0);
    repeat (3) frame(12'd0, 2'b01, 0);

    // Randomized frames.
    do_reset();
    won_frames = 0;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    y = 12'($urandom_range(0, 1));
        2:       y = 12'($urandom_range(768, 4095));
        3, 4, 5: y = 12'($urandom_range(704, 767));
        default: y = 12'($urandom_range(2, 703));
      endcase
      cs = 2'($urandom_range(0, 2));
      frame(y, cs, ($urandom_range(0, 7) == 0));
      if (m_won) won_frames++;
      if (won_frames > 3) begin
        do_reset();
        won_frames = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
